cache_meta_array: RTL and testbench

Per-set, per-way valid/dirty metadata store for the set-associative caches. It is the multi-way successor of the single-bit valid array. It adds:
- per-way masked writes with write-to-read bypass,
- a multi-cycle invalidate sweep sequencer for fence/flush,
- a running count of dirty lines, which the cache controller uses to skip write-back scans when nothing is dirty.

It sits beside the tag and data arrays, inside each cache instance.

---
 rtl/cache_meta_array.sv | 123 ++++++++++++
 tb/tb_cache_meta_array.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_meta_array.sv
// Per-set, per-way valid/dirty metadata with masked writes, same-cycle read bypass,
// a sequential invalidate sweep (IDLE/SWEEP/DONE) and an incrementally kept dirty-line count.
module cache_meta_array #(
  parameter int s_index  = 3,
  parameter int num_ways = 2,
  localparam int num_sets = 2**s_index,
  localparam int cnt_w    = $clog2(num_sets*num_ways+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [s_index-1:0]  windex,
  input  logic [num_ways-1:0] way_mask,
  input  logic                valid_in,
  input  logic                dirty_in,
  input  logic [s_index-1:0]  rindex,
  output logic [num_ways-1:0] valid_out,
  output logic [num_ways-1:0] dirty_out,
  input  logic                inv_req,
  output logic                inv_busy,
  output logic                inv_done,
  output logic [cnt_w-1:0]    dirty_count
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [s_index-1:0] last_set = s_index'(num_sets-1);

  state_t              state, state_next;
  logic [s_index-1:0]  ptr, ptr_next;
  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [cnt_w-1:0]    count_q, count_next;

  logic                wr_en;
  logic [num_ways-1:0] wr_valid, wr_dirty;
  logic [num_ways-1:0] aff_old, aff_new;
  logic [cnt_w-1:0]    inc, dec;

  // Writes are only honoured in IDLE; anything arriving mid-sweep is dropped.
  assign wr_en    = load && (state == IDLE);
  assign wr_valid = (valid_q[windex] & ~way_mask) | (way_mask & {num_ways{valid_in}});
  assign wr_dirty = (dirty_q[windex] & ~way_mask) | (way_mask & {num_ways{dirty_in}});

  assign dirty_count = count_q;

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    inv_busy   = 1'b0;
    inv_done   = 1'b0;
    case (state)
      IDLE: begin
        if (inv_req) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        inv_busy = 1'b1;
        ptr_next = ptr + s_index'(1);
        if (ptr == last_set) state_next = DONE;
      end
      DONE: begin
        inv_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only one set changes per cycle (write target or sweep pointer), so the count
  // moves by the per-way 0->1 and 1->0 transitions of that set alone.
  always_comb begin
    aff_old = wr_en ? dirty_q[windex] : dirty_q[ptr];
    aff_new = wr_en ? wr_dirty : '0;
    inc     = '0;
    dec     = '0;
    for (int w = 0; w < num_ways; w++) begin
      inc = inc + cnt_w'(~aff_old[w] & aff_new[w]);
      dec = dec + cnt_w'(aff_old[w] & ~aff_new[w]);
    end
    count_next = count_q;
    if (wr_en || (state == SWEEP)) count_next = count_q - dec + inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      count_q <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      count_q <= count_next;
      if (wr_en) begin
        valid_q[windex] <= wr_valid;
        dirty_q[windex] <= wr_dirty;
      end else if (state == SWEEP) begin
        valid_q[ptr] <= '0;
        dirty_q[ptr] <= '0;
      end
    end
  end

  always_comb begin
    valid_out = valid_q[rindex];
    dirty_out = dirty_q[rindex];
    if (wr_en && (rindex == windex)) begin
      valid_out = wr_valid;
      dirty_out = wr_dirty;
    end
    if ((state == SWEEP) && (rindex == ptr)) begin
      valid_out = '0;
      dirty_out = '0;
    end
  end

endmodule

// File: tb/tb_cache_meta_array.sv
// Directed bench for cache_meta_array: reset, masked write/bypass, count arithmetic, sweep and collisions.
module tb_cache_meta_array;

  logic       clk = 1'b0;
  logic       rst, load, valid_in, dirty_in, inv_req;
  logic [2:0] windex, rindex;
  logic [1:0] way_mask, valid_out, dirty_out;
  logic       inv_busy, inv_done;
  logic [4:0] dirty_count;

  int n_checks = 0;
  int n_fail   = 0;

  cache_meta_array #(.s_index(3), .num_ways(2)) dut (
    .clk(clk), .rst(rst), .load(load), .windex(windex), .way_mask(way_mask),
    .valid_in(valid_in), .dirty_in(dirty_in), .rindex(rindex),
    .valid_out(valid_out), .dirty_out(dirty_out), .inv_req(inv_req),
    .inv_busy(inv_busy), .inv_done(inv_done), .dirty_count(dirty_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are read before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [1:0] m, input logic v, input logic d);
    load = 1'b1; windex = idx; way_mask = m; valid_in = v; dirty_in = d;
    tick();
    load = 1'b0; way_mask = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_all();
    for (int s = 0; s < 8; s++) do_write(3'(s), 2'b11, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    fill_all();
    n_checks++;
    if (dirty_count !== 5'd16) begin
      n_fail++; $display("FAIL preload_count: got %0d want 16", dirty_count);
    end
    do_reset();
    for (int s = 0; s < 8; s++) begin
      rindex = 3'(s);
      #1;
      n_checks++;
      if (valid_out !== 2'b00 || dirty_out !== 2'b00) begin
        n_fail++; $display("FAIL reset_set%0d: got v=%b d=%b want 00/00", s, valid_out, dirty_out);
      end
    end
    n_checks++;
    if (dirty_count !== 5'd0 || inv_busy !== 1'b0 || inv_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got cnt=%0d busy=%b done=%b want 0/0/0", dirty_count, inv_busy, inv_done);
    end
  endtask

  task automatic test_masked_write();
    do_reset();
    load = 1'b1; windex = 3'd5; way_mask = 2'b10; valid_in = 1'b1; dirty_in = 1'b1; rindex = 3'd5;
    #1;
    n_checks++;
    if (valid_out !== 2'b10 || dirty_out !== 2'b10) begin
      n_fail++; $display("FAIL bypass_w5: got v=%b d=%b want 10/10", valid_out, dirty_out);
    end
    tick();
    load = 1'b0; way_mask = 2'b00;
    #1;
    n_checks++;
    if (valid_out !== 2'b10 || dirty_out !== 2'b10 || dirty_count !== 5'd1) begin
      n_fail++; $display("FAIL stored_w5: got v=%b d=%b cnt=%0d want 10/10/1", valid_out, dirty_out, dirty_count);
    end
    do_write(3'd5, 2'b10, 1'b1, 1'b1);
    n_checks++;
    if (dirty_count !== 5'd1) begin
      n_fail++; $display("FAIL rewrite_count: got %0d want 1", dirty_count);
    end
    // Partial mask: way 0 takes new values, way 1 shows stored ones.
    load = 1'b1; windex = 3'd5; way_mask = 2'b01; valid_in = 1'b1; dirty_in = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 2'b11 || dirty_out !== 2'b10) begin
      n_fail++; $display("FAIL bypass_partial: got v=%b d=%b want 11/10", valid_out, dirty_out);
    end
    tick();
    load = 1'b0; way_mask = 2'b00;
    n_checks++;
    if (dirty_count !== 5'd1) begin
      n_fail++; $display("FAIL partial_count: got %0d want 1", dirty_count);
    end
  endtask

  task automatic test_count();
    do_reset();
    do_write(3'd0, 2'b11, 1'b1, 1'b1);
    do_write(3'd3, 2'b11, 1'b1, 1'b1);
    n_checks++;
    if (dirty_count !== 5'd4) begin
      n_fail++; $display("FAIL count_4: got %0d want 4", dirty_count);
    end
    do_write(3'd3, 2'b01, 1'b1, 1'b0);
    rindex = 3'd3;
    #1;
    n_checks++;
    if (dirty_count !== 5'd3 || valid_out !== 2'b11 || dirty_out !== 2'b10) begin
      n_fail++; $display("FAIL count_3: got cnt=%0d v=%b d=%b want 3/11/10", dirty_count, valid_out, dirty_out);
    end
    do_write(3'd6, 2'b00, 1'b1, 1'b1);
    n_checks++;
    if (dirty_count !== 5'd3) begin
      n_fail++; $display("FAIL mask0_noop: got %0d want 3", dirty_count);
    end
    do_write(3'd0, 2'b10, 1'b0, 1'b0);
    rindex = 3'd0;
    #1;
    n_checks++;
    if (dirty_count !== 5'd2 || valid_out !== 2'b01 || dirty_out !== 2'b01) begin
      n_fail++; $display("FAIL clear_w1: got cnt=%0d v=%b d=%b want 2/01/01", dirty_count, valid_out, dirty_out);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    fill_all();
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rindex = 3'(i);
      #1;
      n_checks++;
      if (inv_busy !== 1'b1 || inv_done !== 1'b0 || dirty_count !== 5'(16 - 2*i) || valid_out !== 2'b00 || dirty_out !== 2'b00) begin
        n_fail++;
        $display("FAIL sweep_step%0d: got busy=%b done=%b cnt=%0d v=%b d=%b want 1/0/%0d/00/00",
                 i, inv_busy, inv_done, dirty_count, valid_out, dirty_out, 16 - 2*i);
      end
      if (i < 7) begin
        rindex = 3'(i + 1);
        #1;
        n_checks++;
        if (valid_out !== 2'b11) begin
          n_fail++; $display("FAIL sweep_ahead%0d: got v=%b want 11", i + 1, valid_out);
        end
      end
      tick();
    end
    n_checks++;
    if (inv_busy !== 1'b0 || inv_done !== 1'b1 || dirty_count !== 5'd0) begin
      n_fail++; $display("FAIL sweep_done: got busy=%b done=%b cnt=%0d want 0/1/0", inv_busy, inv_done, dirty_count);
    end
    for (int s = 0; s < 8; s++) begin
      rindex = 3'(s);
      #1;
      n_checks++;
      if (valid_out !== 2'b00) begin
        n_fail++; $display("FAIL sweep_clear%0d: got v=%b want 00", s, valid_out);
      end
    end
    tick();
    n_checks++;
    if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin
      n_fail++; $display("FAIL sweep_idle: got busy=%b done=%b want 0/0", inv_busy, inv_done);
    end
  endtask

  task automatic test_collisions();
    // Load and inv_req in the same IDLE cycle: write lands, then sweep clears it.
    do_reset();
    load = 1'b1; windex = 3'd2; way_mask = 2'b11; valid_in = 1'b1; dirty_in = 1'b1; inv_req = 1'b1;
    tick();
    load = 1'b0; way_mask = 2'b00; inv_req = 1'b0;
    n_checks++;
    if (dirty_count !== 5'd2 || inv_busy !== 1'b1) begin
      n_fail++; $display("FAIL coll_start: got cnt=%0d busy=%b want 2/1", dirty_count, inv_busy);
    end
    for (int i = 0; i < 8; i++) tick();
    rindex = 3'd2;
    #1;
    n_checks++;
    if (inv_done !== 1'b1 || dirty_count !== 5'd0 || valid_out !== 2'b00) begin
      n_fail++; $display("FAIL coll_cleared: got done=%b cnt=%0d v=%b want 1/0/00", inv_done, dirty_count, valid_out);
    end
    tick();
    // First cycle back in IDLE must accept a write.
    do_write(3'd4, 2'b01, 1'b1, 1'b1);
    rindex = 3'd4;
    #1;
    n_checks++;
    if (valid_out !== 2'b01 || dirty_count !== 5'd1) begin
      n_fail++; $display("FAIL b2b_write: got v=%b cnt=%0d want 01/1", valid_out, dirty_count);
    end

    // Load and second inv_req while sweeping are both ignored.
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    tick();
    tick();
    load = 1'b1; windex = 3'd0; way_mask = 2'b11; valid_in = 1'b1; dirty_in = 1'b1; rindex = 3'd0;
    #1;
    n_checks++;
    if (valid_out !== 2'b00) begin
      n_fail++; $display("FAIL busy_no_bypass: got v=%b want 00", valid_out);
    end
    tick();
    load = 1'b0; way_mask = 2'b00;
    tick();
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (inv_done !== 1'b1 || dirty_count !== 5'd0) begin
      n_fail++; $display("FAIL busy_done: got done=%b cnt=%0d want 1/0", inv_done, dirty_count);
    end
    rindex = 3'd0;
    #1;
    n_checks++;
    if (valid_out !== 2'b00) begin
      n_fail++; $display("FAIL busy_load_dropped: got v=%b want 00", valid_out);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (inv_done !== 1'b0 || inv_busy !== 1'b0) begin
        n_fail++; $display("FAIL no_extra_sweep%0d: got busy=%b done=%b want 0/0", i, inv_busy, inv_done);
      end
    end

    // Reset mid-sweep: immediate IDLE and never a done pulse.
    fill_all();
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    tick();
    tick();
    tick();
    do_reset();
    n_checks++;
    if (inv_busy !== 1'b0 || inv_done !== 1'b0 || dirty_count !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid: got busy=%b done=%b cnt=%0d want 0/0/0", inv_busy, inv_done, dirty_count);
    end
    for (int s = 0; s < 8; s++) begin
      rindex = 3'(s);
      #1;
      n_checks++;
      if (valid_out !== 2'b00 || dirty_out !== 2'b00) begin
        n_fail++; $display("FAIL rst_mid_set%0d: got v=%b d=%b want 00/00", s, valid_out, dirty_out);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (inv_done !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_nodone%0d: got done=%b want 0", i, inv_done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; windex = '0; way_mask = '0; valid_in = 1'b0;
    dirty_in = 1'b0; rindex = '0; inv_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_masked_write();
    test_count();
    test_sweep();
    test_collisions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
